rxe_rxctrl: RTL
===============

RXE_RXCTRL -- requirements
Module: rxectrl

Interface
REQ-001 Parameter MINLEN, default 64, minimum legal frame length in bytes (SFD excluded, FCS included).
REQ-002 Parameter MAXLEN, default 1522, maximum legal frame length in bytes.
REQ-003 Parameter MAXPRE, default 24, maximum preamble nibbles before SFD.
REQ-004 i_clk  in  1  system clock, sole clock; all logic on rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-high.
REQ-006 i_ce  in  1  nibble strobe; all state/counter updates qualified by it.
REQ-007 i_en  in  1  CPU receive enable.
REQ-008 i_rx_dv  in  1  raw MII data-valid (pre-stripper).
REQ-009 i_rx_err  in  1  MII receive error.
REQ-010 i_pre_v  in  1  valid from preamble stripper (post-SFD payload nibble).
REQ-011 i_full  in  1  downstream buffer cannot accept a nibble.
REQ-012 o_pre_en  out  1  enable to preamble stripper.
REQ-013 o_cancel  out  1  cancel to stripper and downstream.
REQ-014 o_start  out  1  one-i_ce pulse, first payload nibble accepted.
REQ-015 o_done  out  1  one-i_ce pulse, frame ended (good or dropped).
REQ-016 o_len  out  11  frame length in bytes, valid with o_done, held until next o_done.
REQ-017 o_stat  out  5  {align, runt, toolong, overflow, rxerr}, valid with o_done, held.
REQ-018 o_frames  out  16  good-frame count, wraps.
REQ-019 o_drops  out  16  dropped-frame count, saturates at 16'hffff.

Function
REQ-020 States SHALL be DISABLED, IDLE, PREAMBLE, DATA, DROP; transitions only on cycles with i_ce=1.
REQ-021 DISABLED: o_pre_en=0; go IDLE when i_en=1 and i_rx_dv=0 (never join a frame mid-stream).
REQ-022 IDLE: o_pre_en=1; i_en=0 -> DISABLED; else i_rx_dv=1 -> PREAMBLE, preamble counter cleared.
REQ-023 PREAMBLE: count nibbles with i_rx_dv=1; i_pre_v=1 -> DATA, o_start pulse, nibble count=1; i_rx_dv=0 -> IDLE silently, no o_done; count reaching MAXPRE with no i_pre_v -> DROP, stat all zero, still counted in o_drops.
REQ-024 DATA: each i_ce with i_pre_v=1 increments 12-bit nibble count; i_en changes ignored until frame ends.
REQ-025 DATA error priority, highest first: i_rx_err -> rxerr; i_full with i_pre_v -> overflow; nibble count reaching 2*MAXLEN+1 -> toolong; any -> DROP.
REQ-026 DATA, i_pre_v=0: o_done pulse; o_len=count/2 (truncated); align=count[0]; runt=(o_len<MINLEN); good frame (no align/runt) increments o_frames, else o_drops; next IDLE, or DISABLED if i_en=0.
REQ-027 DROP: o_cancel=1 held every cycle in DROP; exit when i_rx_dv=0 and i_pre_v=0 on an i_ce cycle: o_done pulse, o_len=bytes counted so far, o_stat with latched cause, o_drops++; next IDLE or DISABLED per i_en.
REQ-028 o_cancel, o_start, o_done registered: asserted the cycle after the qualifying i_ce cycle; o_start/o_done deassert at next i_ce.
REQ-029 Simultaneous end (i_pre_v falls) and error on same i_ce: error wins, DROP path taken.
REQ-030 o_len/o_stat SHALL update only at o_done; nibble count SHALL not overflow (saturate at 2*MAXLEN+1).
REQ-031 i_ce=0 cycles: all state, counters, outputs hold (pulses extend until next i_ce).

Reset
REQ-032 i_reset=1: state DISABLED, o_pre_en=0, o_cancel=0, o_start=0, o_done=0, o_len=0, o_stat=0, o_frames=0, o_drops=0; wins over i_ce.
REQ-033 Reset mid-frame: no o_done issued; after release, block waits for i_rx_dv=0 before accepting a frame.

Verification
REQ-034 i_en=1, i_ce every cycle, 15 nibbles 5 + D, 128 payload nibbles -> o_start once, o_done with o_len=64, o_stat=0, o_frames=1.
REQ-035 Same, 60 payload nibbles -> o_len=30, runt=1, o_drops=1, o_frames unchanged; 61 nibbles -> o_len=30, align=1, runt=1.
REQ-036 i_rx_err at payload nibble 20 -> o_cancel from next cycle until i_rx_dv and i_pre_v low, o_done with rxerr=1, o_len=10.
REQ-037 3046 payload nibbles, MAXLEN=1522 -> DROP at nibble 3045, toolong=1; i_full at nibble 7 -> overflow=1.
REQ-038 i_en raised mid-frame -> stays DISABLED until i_rx_dv low, next frame accepted; i_ce toggling 1-of-10 -> identical o_len/o_stat results.

Source files
------------

// File: rtl/rxe_rxctrl.sv
// Receive-side frame controller: tracks preamble/payload of an MII frame nibble by nibble,
// classifies the frame at its end, and keeps good/dropped frame statistics.
module rxe_rxctrl #(
  parameter int MINLEN = 64,
  parameter int MAXLEN = 1522,
  parameter int MAXPRE = 24
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_en,
  input  logic        i_rx_dv,
  input  logic        i_rx_err,
  input  logic        i_pre_v,
  input  logic        i_full,
  output logic        o_pre_en,
  output logic        o_cancel,
  output logic        o_start,
  output logic        o_done,
  output logic [10:0] o_len,
  output logic [4:0]  o_stat,
  output logic [15:0] o_frames,
  output logic [15:0] o_drops
);

  localparam int              PW       = (MAXPRE > 1) ? $clog2(MAXPRE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(MAXPRE - 1);
  localparam logic [11:0]     NIB_MAX  = 12'(2 * MAXLEN + 1);
  localparam logic [10:0]     LEN_MIN  = 11'(MINLEN);

  typedef enum logic [2:0] {
    S_DIS,
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } state_e;

  typedef struct packed {
    logic align;
    logic runt;
    logic toolong;
    logic overflow;
    logic rxerr;
  } stat_t;

  state_e          state_q;
  logic [PW-1:0]   pre_q;
  logic [11:0]     nib_q;
  logic [11:0]     nib_d;
  logic [11:0]     nib_inc;
  stat_t           cause_q;
  stat_t           end_stat;
  logic [10:0]     end_len;
  logic            err_now;
  logic            ovf_now;
  logic            long_now;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  // Nibble count saturates so an endless stream can never wrap the length.
  always_comb begin
    nib_inc  = (nib_q == NIB_MAX) ? nib_q : nib_q + 12'd1;
    nib_d    = i_pre_v ? nib_inc : nib_q;
    end_len  = nib_q[11:1];
    end_stat = '0;
    end_stat.align = nib_q[0];
    end_stat.runt  = (end_len < LEN_MIN);
    err_now  = i_rx_err;
    ovf_now  = i_full && i_pre_v;
    long_now = (nib_d == NIB_MAX);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_DIS;
      pre_q    <= '0;
      nib_q    <= '0;
      cause_q  <= '0;
      o_pre_en <= 1'b0;
      o_cancel <= 1'b0;
      o_start  <= 1'b0;
      o_done   <= 1'b0;
      o_len    <= '0;
      o_stat   <= '0;
      o_frames <= '0;
      o_drops  <= '0;
    end else if (i_ce) begin
      o_start <= 1'b0;
      o_done  <= 1'b0;
      unique case (state_q)
        S_DIS: begin
          // Only arm on a quiet line so we never lock onto a frame mid-stream.
          if (i_en && !i_rx_dv) begin
            state_q  <= S_IDLE;
            o_pre_en <= 1'b1;
          end
        end
        S_IDLE: begin
          if (!i_en) begin
            state_q  <= S_DIS;
            o_pre_en <= 1'b0;
          end else if (i_rx_dv) begin
            state_q <= S_PRE;
            pre_q   <= '0;
          end
        end
        S_PRE: begin
          if (i_pre_v) begin
            state_q <= S_DATA;
            o_start <= 1'b1;
            nib_q   <= 12'd1;
            cause_q <= '0;
          end else if (!i_rx_dv) begin
            state_q <= S_IDLE;
          end else if (pre_q == PRE_LAST) begin
            state_q  <= S_DROP;
            o_cancel <= 1'b1;
            nib_q    <= '0;
            cause_q  <= '0;
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
        S_DATA: begin
          nib_q <= nib_d;
          if (err_now || ovf_now || long_now) begin
            state_q          <= S_DROP;
            o_cancel         <= 1'b1;
            cause_q          <= '0;
            cause_q.rxerr    <= err_now;
            cause_q.overflow <= !err_now && ovf_now;
            cause_q.toolong  <= !err_now && !ovf_now;
          end else if (!i_pre_v) begin
            o_done <= 1'b1;
            o_len  <= end_len;
            o_stat <= end_stat;
            if (end_stat == '0) o_frames <= o_frames + 16'd1;
            else                o_drops  <= sat_inc(o_drops);
            if (i_en) begin
              state_q <= S_IDLE;
            end else begin
              state_q  <= S_DIS;
              o_pre_en <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (!i_rx_dv && !i_pre_v) begin
            o_done   <= 1'b1;
            o_cancel <= 1'b0;
            o_len    <= nib_q[11:1];
            o_stat   <= cause_q;
            o_drops  <= sat_inc(o_drops);
            if (i_en) begin
              state_q <= S_IDLE;
            end else begin
              state_q  <= S_DIS;
              o_pre_en <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= S_DIS;
          o_pre_en <= 1'b0;
          o_cancel <= 1'b0;
        end
      endcase
    end
  end

endmodule
